uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: number of data bits per frame, received LSB first.
REQ-002 SHALL have parameter STOP_TICK, default 16: number of i_sample_tick periods in the stop bit.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 SHALL have port i_sample_tick  input  1  one-clk strobe at 16x baud rate.
REQ-006 SHALL have port i_rx  input  1  asynchronous serial line; idle high.
REQ-007 SHALL have port o_rx_data  output  DATA_BITS  last received data word.
REQ-008 SHALL have port o_rx_done_tick  output  1  one-clk pulse when a frame completes.
REQ-009 SHALL have port o_frame_err  output  1  stop bit sampled low on last completed frame.

Function
REQ-010 SHALL pass i_rx through a 2-flop synchronizer; both flops reset to 1; all FSM decisions use the second flop output (rx_s).
REQ-011 SHALL implement FSM states S_IDLE, S_START, S_DATA, S_STOP; undefined encodings return to S_IDLE.
REQ-012 S_IDLE: on rx_s==0 (independent of i_sample_tick), go to S_START and clear tick counter.
REQ-013 S_START: on each i_sample_tick, increment tick counter; when counter==7 (mid start bit), if rx_s==0 go to S_DATA and clear tick and bit counters; if rx_s==1, treat it as a glitch and return to S_IDLE with no output change.
REQ-014 S_DATA: on i_sample_tick with counter==15, shift rx_s into shift-register MSB (shift right), clear tick counter, and then go to S_STOP if bit counter==DATA_BITS-1, else increment the bit counter; otherwise, on i_sample_tick, increment the tick counter.
REQ-015 Tick counter SHALL be 4 bits wide; bit counter SHALL be wide enough for DATA_BITS-1; no arithmetic wraps past the terminal counts.
REQ-016 S_STOP: on i_sample_tick with counter==STOP_TICK-1, in a single cycle: pulse o_rx_done_tick, load o_rx_data from the shift register, set o_frame_err=~rx_s, and return to S_IDLE; otherwise, on i_sample_tick, increment the tick counter.
REQ-017 o_rx_done_tick SHALL be registered and high exactly one clk per frame, in the cycle after the terminal STOP tick.
REQ-018 o_rx_data and o_frame_err SHALL hold their values until the next frame completes; a frame with a framing error still updates o_rx_data and pulses o_rx_done_tick.
REQ-019 Without i_sample_tick, the FSM SHALL hold its state and counters, except for the S_IDLE start detection.
REQ-020 A line held low (break) SHALL produce one frame with data 0 and o_frame_err=1, then re-enter S_START only after rx_s is seen low again in S_IDLE (a continuous low re-triggers immediately).
REQ-021 From the first low sample in S_IDLE, frame completion latency SHALL be 8+16*DATA_BITS+STOP_TICK sample ticks plus at most 1 clk.

Reset
REQ-022 While rst_n==0: state=S_IDLE, counters=0, shift register=0, o_rx_data=0, o_rx_done_tick=0, o_frame_err=0, synchronizer=1.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no done pulse; after release, the block SHALL wait in S_IDLE for a new falling edge.

Verification
REQ-024 Send frame 0x55 with a valid stop bit at ticks every 4 clk -> one o_rx_done_tick, o_rx_data=0x55, o_frame_err=0.
REQ-025 Send 0xA3 then 0x0F back-to-back with no idle gap -> two done pulses, data 0xA3 then 0x0F, o_frame_err=0 both times.
REQ-026 Apply a 3-tick low glitch on idle line -> no done pulse, FSM back in S_IDLE, o_rx_data unchanged.
REQ-027 Send 0xC4 with the stop bit driven low -> done pulse, o_rx_data=0xC4, o_frame_err=1; next good frame 0x12 clears o_frame_err.
REQ-028 Assert rst_n low during data bit 4 of 0xFF, release, then send 0x3C -> no pulse for the aborted frame; one pulse with o_rx_data=0x3C.
REQ-029 Hold the line low for 12 bit times -> first frame data 0x00, o_frame_err=1; no further pulse until the line returns high and a new start bit occurs, except re-triggering as defined in REQ-020.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// UART receiver for 8N1-style framing. It oversamples the serial line at 16x
// the baud rate (i_sample_tick), finds the middle of the start bit, then samples
// each data bit (LSB first) and the stop bit at their centres.
//
// Parameters
//   DATA_BITS  data bits per frame (received LSB first)
//   STOP_TICK  sample-tick periods spent in the stop bit (1..16)
//
// Ports
//   clk             clock; every state update happens on its rising edge
//   rst_n           asynchronous active-low reset
//   i_sample_tick   one-clk strobe at 16x the baud rate
//   i_rx            asynchronous serial input, idle high
//   o_rx_data       last received data word, held until the next frame ends
//   o_rx_done_tick  one-clk pulse in the cycle after a frame completes
//   o_frame_err     stop bit of the last completed frame was sampled low
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int STOP_TICK = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_sample_tick,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_rx_done_tick,
  output logic                 o_frame_err
);

  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Terminal counts: mid start bit, mid data bit, end of stop bit.
  localparam logic [3:0]       START_MID = 4'd7;
  localparam logic [3:0]       DATA_LAST = 4'd15;
  localparam logic [3:0]       STOP_LAST = 4'(STOP_TICK - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; both flops reset to the idle (high) line level so a
  // reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge value of the others, matching real hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver state and registered outputs
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [3:0]             tick_q,  tick_d;
  logic [BIT_W-1:0]       bit_q,   bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic [DATA_BITS-1:0]   data_d;
  logic                   err_d;
  logic                   done_d;
  logic [DATA_BITS:0]     shift_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      tick_q         <= '0;
      bit_q          <= '0;
      shreg_q        <= '0;
      o_rx_data      <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      bit_q          <= bit_d;
      shreg_q        <= shreg_d;
      o_rx_data      <= data_d;
      o_rx_done_tick <= done_d;
      o_frame_err    <= err_d;
    end
  end

  // New bit enters at the MSB; after DATA_BITS shifts the first bit is the LSB.
  assign shift_in = {rx_s, shreg_q};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = o_rx_data;
    err_d   = o_frame_err;
    done_d  = 1'b0;

    case (state_q)
      // Start detection runs every clk, not only on sample ticks.
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end

      S_START: begin
        if (i_sample_tick) begin
          if (tick_q == START_MID) begin
            if (!rx_s) begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              // Line went high again before mid start bit: a glitch.
              state_d = S_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (i_sample_tick) begin
          if (tick_q == DATA_LAST) begin
            shreg_d = shift_in[DATA_BITS:1];
            tick_d  = '0;
            if (bit_q == BIT_LAST) begin
              state_d = S_STOP;
            end else begin
              bit_d = bit_q + BIT_ONE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      S_STOP: begin
        if (i_sample_tick) begin
          if (tick_q == STOP_LAST) begin
            done_d  = 1'b1;
            data_d  = shreg_q;
            err_d   = ~rx_s;
            state_d = S_IDLE;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule
